mux_sel_reg: RTL and testbench

Parametrised, registered successor to the 3-input/2-constant destination selector. It picks one of `N_DATA` data words or one of two constant codes (default: stack pointer 29, return address 31). The result is captured into a holding register under a load strobe, and selector codes that map to nothing are flagged and counted. It sits between the control unit and the register-file write-address/shamt paths, so the selected value stays stable across multicycle states without the control unit re-driving the selector.

---
 rtl/mux_defs.sv | 9 +
 rtl/mux_n_core.sv | 39 +++
 rtl/mux_sel_reg.sv | 89 ++++++++
 tb/tb_mux_sel_reg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_defs.sv
// Shared constants for the registered destination selector: default constant register
// codes and the error-counter width.
package mux_defs;

  localparam int unsigned REG_SP    = 29;
  localparam int unsigned REG_RA    = 31;
  localparam int unsigned ERR_CNT_W = 4;

endpackage

// File: rtl/mux_n_core.sv
// Combinational code map: N data slices, then two constants, anything above is unmapped
// and falls back to slice 0.
module mux_n_core #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned N_DATA = 3,
  parameter int unsigned SEL_W  = 3
) (
  input  logic [SEL_W-1:0]        i_selector,
  input  logic [N_DATA*WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0]        i_const_a,
  input  logic [WIDTH-1:0]        i_const_b,
  output logic [WIDTH-1:0]        o_value,
  output logic                    o_unmapped
);

  logic w_hit;

  always_comb begin
    o_value    = i_data[WIDTH-1:0];
    o_unmapped = 1'b0;
    w_hit      = 1'b0;
    for (int k = 0; k < int'(N_DATA); k++) begin
      if (i_selector == SEL_W'(k)) begin
        o_value = i_data[k*WIDTH +: WIDTH];
        w_hit   = 1'b1;
      end
    end
    if (!w_hit) begin
      if (i_selector == SEL_W'(N_DATA)) begin
        o_value = i_const_a;
      end else if (i_selector == SEL_W'(N_DATA + 1)) begin
        o_value = i_const_b;
      end else begin
        o_unmapped = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_reg.sv
// Registered destination selector: captures the mapped value on load and keeps a sticky
// flag plus a saturating count of loads that used an unmapped selector code.
module mux_sel_reg
  import mux_defs::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_DATA  = 3,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned CONST_A = REG_SP,
  parameter int unsigned CONST_B = REG_RA
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [SEL_W-1:0]        selector,
  input  logic [N_DATA*WIDTH-1:0] data_in,
  input  logic                    clr_err,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        last_sel,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  if (N_DATA < 1 || N_DATA > 6) begin : gen_bad_n_data
    $fatal(1, "mux_sel_reg: N_DATA must be in 1..6");
  end
  if ((64'd1 << SEL_W) < 64'(N_DATA + 2)) begin : gen_bad_sel_w
    $fatal(1, "mux_sel_reg: SEL_W too small to encode N_DATA+2 codes");
  end

  localparam logic [ERR_CNT_W-1:0] ErrCntMax = '1;

  logic [WIDTH-1:0]     w_value;
  logic                 w_unmapped;
  logic [WIDTH-1:0]     r_data_out;
  logic                 r_out_valid;
  logic [SEL_W-1:0]     r_last_sel;
  logic                 r_sel_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  mux_n_core #(
    .WIDTH  (WIDTH),
    .N_DATA (N_DATA),
    .SEL_W  (SEL_W)
  ) u_core (
    .i_selector (selector),
    .i_data     (data_in),
    .i_const_a  (WIDTH'(CONST_A)),
    .i_const_b  (WIDTH'(CONST_B)),
    .o_value    (w_value),
    .o_unmapped (w_unmapped)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_last_sel  <= '0;
      r_sel_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (load) begin
        r_data_out  <= w_value;
        r_last_sel  <= selector;
        r_out_valid <= 1'b1;
      end
      // An erroring load beats a simultaneous clear: the count restarts at 1.
      if (load && w_unmapped) begin
        r_sel_err <= 1'b1;
        if (clr_err) begin
          r_err_cnt <= ERR_CNT_W'(1);
        end else if (r_err_cnt != ErrCntMax) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end else if (clr_err) begin
        r_sel_err <= 1'b0;
        r_err_cnt <= '0;
      end
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign last_sel  = r_last_sel;
  assign sel_err   = r_sel_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Directed bench for mux_sel_reg: default instance plus a reparametrised 8-bit, 5-input one.
module tb_mux_sel_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [2:0]  selector;
  logic [95:0] data_in;
  logic        clr_err;
  logic [31:0] data_out;
  logic        out_valid;
  logic [2:0]  last_sel;
  logic        sel_err;
  logic [3:0]  err_cnt;

  logic        load2;
  logic [2:0]  selector2;
  logic [39:0] data_in2;
  logic        clr_err2;
  logic [7:0]  data_out2;
  logic        out_valid2;
  logic [2:0]  last_sel2;
  logic        sel_err2;
  logic [3:0]  err_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_sel_reg dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .selector  (selector),
    .data_in   (data_in),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .out_valid (out_valid),
    .last_sel  (last_sel),
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
  );

  mux_sel_reg #(
    .WIDTH   (8),
    .N_DATA  (5),
    .SEL_W   (3),
    .CONST_A (7),
    .CONST_B (9)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .load      (load2),
    .selector  (selector2),
    .data_in   (data_in2),
    .clr_err   (clr_err2),
    .data_out  (data_out2),
    .out_valid (out_valid2),
    .last_sel  (last_sel2),
    .sel_err   (sel_err2),
    .err_cnt   (err_cnt2)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    load     = 1'b1;
    selector = 3'b001;
    data_in  = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    clr_err  = 1'b0;
    load2    = 1'b1;
    selector2 = 3'd2;
    data_in2 = 40'h55_44_33_22_11;
    clr_err2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (data_out !== 32'd0) begin
        errors++; $display("FAIL reset_data_out cyc%0d: got %h want 0", i, data_out);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", i, out_valid);
      end
      checks++;
      if (err_cnt !== 4'd0 || sel_err !== 1'b0 || last_sel !== 3'd0) begin
        errors++;
        $display("FAIL reset_err cyc%0d: got cnt=%0d err=%b last=%0d want 0/0/0",
                 i, err_cnt, sel_err, last_sel);
      end
      checks++;
      if (data_out2 !== 8'd0 || out_valid2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_dut2 cyc%0d: got %h/%b want 00/0", i, data_out2, out_valid2);
      end
    end
    reset = 1'b0;
    load  = 1'b0;
    load2 = 1'b0;
  endtask

  task automatic test_default_map();
    logic [31:0] exp_tab [5];
    exp_tab = '{32'hA, 32'hB, 32'hC, 32'd29, 32'd31};
    for (int c = 0; c < 5; c++) begin
      load     = 1'b1;
      selector = 3'(c);
      tick();
      checks++;
      if (data_out !== exp_tab[c] || out_valid !== 1'b1 || last_sel !== 3'(c)) begin
        errors++;
        $display("FAIL map_code%0d: got data=%h valid=%b last=%0d want data=%h valid=1 last=%0d",
                 c, data_out, out_valid, last_sel, exp_tab[c], c);
      end
      checks++;
      if (sel_err !== 1'b0) begin
        errors++; $display("FAIL map_sel_err code%0d: got %b want 0", c, sel_err);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_hold();
    load     = 1'b1;
    selector = 3'b001;
    tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      selector = 3'($urandom);
      data_in  = {$urandom, $urandom, $urandom};
      tick();
      checks++;
      if (data_out !== 32'hB || last_sel !== 3'b001) begin
        errors++;
        $display("FAIL hold cyc%0d: got data=%h last=%0d want data=0000000b last=1",
                 i, data_out, last_sel);
      end
    end
    data_in = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
  endtask

  task automatic test_error_sat();
    int exp_cnt;
    for (int i = 0; i < 17; i++) begin
      load     = 1'b1;
      selector = 3'b110;
      tick();
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      checks++;
      if (data_out !== 32'hA || sel_err !== 1'b1 || err_cnt !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL err_load%0d: got data=%h err=%b cnt=%0d want data=0000000a err=1 cnt=%0d",
                 i, data_out, sel_err, err_cnt, exp_cnt);
      end
    end
    load    = 1'b0;
    clr_err = 1'b1;
    tick();
    checks++;
    if (sel_err !== 1'b0 || err_cnt !== 4'd0) begin
      errors++; $display("FAIL clr_err: got err=%b cnt=%0d want 0/0", sel_err, err_cnt);
    end
    load     = 1'b1;
    selector = 3'b111;
    tick();
    checks++;
    if (sel_err !== 1'b1 || err_cnt !== 4'd1 || data_out !== 32'hA) begin
      errors++;
      $display("FAIL clr_and_err: got err=%b cnt=%0d data=%h want 1/1/0000000a",
               sel_err, err_cnt, data_out);
    end
    load    = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    load     = 1'b1;
    selector = 3'b100;
    tick();
    checks++;
    if (data_out !== 32'd31) begin
      errors++; $display("FAIL mid_pre_load: got %h want 0000001f", data_out);
    end
    load  = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (data_out !== 32'd0 || out_valid !== 1'b0 || last_sel !== 3'd0 ||
        sel_err !== 1'b0 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got data=%h valid=%b last=%0d err=%b cnt=%0d want all 0",
               data_out, out_valid, last_sel, sel_err, err_cnt);
    end
    reset    = 1'b0;
    load     = 1'b1;
    selector = 3'b011;
    tick();
    checks++;
    if (data_out !== 32'd29 || out_valid !== 1'b1 || last_sel !== 3'b011) begin
      errors++;
      $display("FAIL mid_post_load: got data=%h valid=%b last=%0d want 0000001d/1/3",
               data_out, out_valid, last_sel);
    end
    load = 1'b0;
  endtask

  task automatic test_reparam();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'd7, 8'd9, 8'h11};
    for (int c = 0; c < 8; c++) begin
      load2     = 1'b1;
      selector2 = 3'(c);
      tick();
      checks++;
      if (data_out2 !== exp_tab[c] || sel_err2 !== (c == 7)) begin
        errors++;
        $display("FAIL reparam_code%0d: got data=%h err=%b want data=%h err=%b",
                 c, data_out2, sel_err2, exp_tab[c], (c == 7));
      end
    end
    checks++;
    if (err_cnt2 !== 4'd1 || last_sel2 !== 3'd7) begin
      errors++;
      $display("FAIL reparam_cnt: got cnt=%0d last=%0d want 1/7", err_cnt2, last_sel2);
    end
    load2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_map();
    test_hold();
    test_error_sat();
    test_reset_mid();
    test_reparam();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
